// File: rtl/da_serial_mac3.sv
// da_serial_mac3: bit-serial DA engine computing y = -2*x0 + 3*x1 + x2, MSB first.
// Define DA_LUT_REG_EN to register the LUT output (one extra SHIFT cycle, same result).
module da_serial_mac3 #(
  parameter int W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] x0,
  input  logic signed [W-1:0] x1,
  input  logic signed [W-1:0] x2,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W+2:0] y
);
  localparam int OW = W + 3;
`ifdef DA_LUT_REG_EN
  localparam int CW = $clog2(W + 1);
`else
  localparam int CW = $clog2(W);
`endif
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t               state_q;
  logic [W-1:0]         s0_q, s1_q, s2_q;
  logic [CW-1:0]        cnt_q;
  logic signed [OW-1:0] acc_q, acc_d, term;
  logic signed [3:0]    lut;
  logic [2:0]           addr;
  logic                 prime, first, last;
  assign addr = {s2_q[W-1], s1_q[W-1], s0_q[W-1]};
  always_comb begin
    lut = 4'sd0;
    case (addr)
      3'd1:    lut = -4'sd2;
      3'd2:    lut = 4'sd3;
      3'd3:    lut = 4'sd1;
      3'd4:    lut = 4'sd1;
      3'd5:    lut = -4'sd1;
      3'd6:    lut = 4'sd4;
      3'd7:    lut = 4'sd2;
      default: lut = 4'sd0;
    endcase
  end
`ifdef DA_LUT_REG_EN
  logic signed [3:0] lut_q;
  assign term  = {{(OW-4){lut_q[3]}}, lut_q};
  assign prime = cnt_q == '0;
  assign first = cnt_q == CW'(1);
  assign last  = cnt_q == CW'(W);
`else
  assign term  = {{(OW-4){lut[3]}}, lut};
  assign prime = 1'b0;
  assign first = cnt_q == '0;
  assign last  = cnt_q == CW'(W - 1);
`endif
  // The sign-bit slice carries negative weight, so the first real term is subtracted.
  assign acc_d = prime ? acc_q : first ? -term : (acc_q <<< 1) + term;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      y         <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      s0_q      <= '0;
      s1_q      <= '0;
      s2_q      <= '0;
`ifdef DA_LUT_REG_EN
      lut_q     <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          s0_q     <= x0;
          s1_q     <= x1;
          s2_q     <= x2;
          cnt_q    <= '0;
          in_ready <= 1'b0;
          state_q  <= SHIFT;
        end
        SHIFT: begin
          s0_q  <= s0_q << 1;
          s1_q  <= s1_q << 1;
          s2_q  <= s2_q << 1;
`ifdef DA_LUT_REG_EN
          lut_q <= lut;
`endif
          acc_q <= acc_d;
          cnt_q <= last ? '0 : cnt_q + 1'b1;
          if (last) begin
            y         <= acc_d;
            out_valid <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
